instr_fetch_unit: RTL and testbench

Per-core instruction fetch stage between the program counter and the decode/execute logic. Fetches the word at the current PC from the shared instruction memory over a request/acknowledge handshake, holds it in an instruction register for the consumer, and drives the PC update controls `gamma`, `s` and `we` so the PC advances or takes a jump. Jump and halt detection happen here, so the PC never advances until the fetched instruction has been accepted downstream.

---
 rtl/instr_fetch_unit.sv | 91 +++++++++
 tb/tb_instr_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetches the word at pc_in over a req/ack handshake,
// holds it for the consumer and drives PC update controls on acceptance.
module instr_fetch_unit #(
  parameter int         INSTR_W = 16,
  parameter logic [3:0] OP_JMP  = 4'hA,
  parameter logic [3:0] OP_JMPZ = 4'hB,
  parameter logic [3:0] OP_HALT = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         pc_in,
  output logic               imem_req,
  output logic [5:0]         imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               zero_flag,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [5:0]         gamma,
  output logic               s,
  output logic               we,
  output logic               halted
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [3:0]         opcode_s;
  logic               accept_s;
  logic               take_jump_s;

  assign opcode_s    = ir_q[INSTR_W-1:INSTR_W-4];
  assign accept_s    = (state_q == ST_ISSUE) && ir_ready;
  assign take_jump_s = (opcode_s == OP_JMP) || ((opcode_s == OP_JMPZ) && zero_flag);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
        else       state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_ISSUE: begin
        if (ir_ready) state_d = (opcode_s == OP_HALT) ? ST_HALT : ST_REQ;
        else          state_d = ST_ISSUE;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Reset discards any in-flight ack, so no capture or PC write survives it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    imem_req  = (state_q == ST_REQ);
    imem_addr = imem_req ? pc_in : 6'd0;
    ir_valid  = (state_q == ST_ISSUE);
    we        = accept_s;
    s         = accept_s && take_jump_s;
    gamma     = s ? ir_q[5:0] : 6'd0;
    halted    = (state_q == ST_HALT);
    ir_out    = ir_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a small PC model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  pc_in;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        zero_flag;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;
  logic [5:0]  gamma;
  logic        s;
  logic        we;
  logic        halted;

  logic        pc_load;
  logic [5:0]  pc_val;
  int          checks;
  int          failures;

  instr_fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc_in     (pc_in),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .zero_flag (zero_flag),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .gamma     (gamma),
    .s         (s),
    .we        (we),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the PC module driven by we/s/gamma.
  always @(posedge clk) begin
    if (pc_load)  pc_in <= pc_val;
    else if (we)  pc_in <= s ? gamma : pc_in + 6'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
    zero_flag = 1'b0; ir_ready = 1'b0; pc_load = 1'b1; pc_val = 6'd5;

    // Reset / idle
    tick(); tick();
    rst = 1'b1; pc_load = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    settle();
    check_eq("idle_req",   imem_req, 1'b0);
    check_eq("idle_valid", ir_valid, 1'b0);
    check_eq("idle_we",    we, 1'b0);
    check_eq("idle_ir",    ir_out, 16'h0000);
    check_eq("idle_addr",  imem_addr, 6'd0);
    check_eq("idle_pc",    pc_in, 6'd5);

    // Sequential fetch at pc=5
    start = 1'b1; tick(); start = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h1234; settle();
    check_eq("seq_req",  imem_req, 1'b1);
    check_eq("seq_addr", imem_addr, 6'd5);
    check_eq("seq_nvld", ir_valid, 1'b0);
    tick(); imem_ack = 1'b0; ir_ready = 1'b1; settle();
    check_eq("seq_ir",  ir_out, 16'h1234);
    check_eq("seq_vld", ir_valid, 1'b1);
    check_eq("seq_we",  we, 1'b1);
    check_eq("seq_s",   s, 1'b0);
    check_eq("seq_gam", gamma, 6'd0);
    tick(); settle();
    check_eq("seq_req2",  imem_req, 1'b1);
    check_eq("seq_addr2", imem_addr, 6'd6);
    check_eq("seq_we0",   we, 1'b0);

    // JMP 0xA018
    imem_ack = 1'b1; imem_rdata = 16'hA018; tick(); imem_ack = 1'b0; settle();
    check_eq("jmp_s",   s, 1'b1);
    check_eq("jmp_gam", gamma, 6'd24);
    check_eq("jmp_we",  we, 1'b1);
    tick(); settle();
    check_eq("jmp_addr", imem_addr, 6'd24);

    // JMPZ not taken
    zero_flag = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hB01F; tick(); imem_ack = 1'b0; settle();
    check_eq("jz0_s",   s, 1'b0);
    check_eq("jz0_gam", gamma, 6'd0);
    check_eq("jz0_we",  we, 1'b1);
    tick(); settle();
    check_eq("jz0_addr", imem_addr, 6'd25);

    // JMPZ taken
    imem_ack = 1'b1; imem_rdata = 16'hB01F; tick(); imem_ack = 1'b0;
    zero_flag = 1'b1; settle();
    check_eq("jz1_s",   s, 1'b1);
    check_eq("jz1_gam", gamma, 6'd31);
    tick(); zero_flag = 1'b0; settle();
    check_eq("jz1_addr", imem_addr, 6'd31);

    // Memory back-pressure
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("mbp_req",  imem_req, 1'b1);
      check_eq("mbp_addr", imem_addr, 6'd31);
      check_eq("mbp_vld",  ir_valid, 1'b0);
      tick(); settle();
    end
    imem_ack = 1'b1; imem_rdata = 16'h2222; tick();
    // Stray ack while stalled in ISSUE must be ignored
    imem_rdata = 16'h5555; settle();
    for (int i = 0; i < 4; i++) begin
      check_eq("cbp_vld", ir_valid, 1'b1);
      check_eq("cbp_ir",  ir_out, 16'h2222);
      check_eq("cbp_we",  we, 1'b0);
      tick(); settle();
    end
    imem_ack = 1'b0; ir_ready = 1'b1; settle();
    check_eq("cbp_we1", we, 1'b1);
    check_eq("cbp_ir1", ir_out, 16'h2222);
    tick(); ir_ready = 1'b0; settle();
    check_eq("cbp_we2",  we, 1'b0);
    check_eq("cbp_addr", imem_addr, 6'd32);

    // Reset in REQ with ack pending
    imem_ack = 1'b1; imem_rdata = 16'h3333; rst = 1'b0; tick();
    rst = 1'b1; imem_ack = 1'b0; settle();
    check_eq("rreq_ir",  ir_out, 16'h0000);
    check_eq("rreq_req", imem_req, 1'b0);
    check_eq("rreq_we",  we, 1'b0);
    check_eq("rreq_vld", ir_valid, 1'b0);
    check_eq("rreq_pc",  pc_in, 6'd32);

    // Reset in ISSUE
    start = 1'b1; tick(); start = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h4444; tick(); imem_ack = 1'b0; settle();
    check_eq("riss_vld", ir_valid, 1'b1);
    rst = 1'b0; tick(); rst = 1'b1; ir_ready = 1'b1; settle();
    check_eq("riss_ir",  ir_out, 16'h0000);
    check_eq("riss_vld0", ir_valid, 1'b0);
    check_eq("riss_we",  we, 1'b0);
    check_eq("riss_pc",  pc_in, 6'd32);

    // Halt
    start = 1'b1; tick(); start = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hF000; tick(); imem_ack = 1'b0; settle();
    check_eq("hlt_we",  we, 1'b1);
    check_eq("hlt_s",   s, 1'b0);
    check_eq("hlt_h0",  halted, 1'b0);
    tick(); settle();
    check_eq("hlt_h1",  halted, 1'b1);
    check_eq("hlt_req", imem_req, 1'b0);
    check_eq("hlt_we0", we, 1'b0);
    check_eq("hlt_ir",  ir_out, 16'hF000);
    check_eq("hlt_pc",  pc_in, 6'd33);
    start = 1'b1; tick(); start = 1'b0; tick(); settle();
    check_eq("hlt_h2",   halted, 1'b1);
    check_eq("hlt_req2", imem_req, 1'b0);
    check_eq("hlt_vld",  ir_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
